// File: rtl/i2c_deserializer_pkg.sv
// i2c_deserializer_pkg
//   Shared definitions for the I2C slave receive path: FSM state encoding,
//   the default device address, the byte width, the bus-condition bundle
//   passed from the condition detector to the FSM, and an address-match helper.
package i2c_deserializer_pkg;

    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h50;
    localparam int         BITS_PER_BYTE      = 8;

    typedef enum logic [3:0] {
        IDLE,
        DEV_ADDR,
        ACK_DEV,
        REG_ADDR,
        ACK_REG,
        WR_DATA,
        ACK_WR,
        RD_BYTE,
        MST_ACK
    } i2c_state_e;

    // Single-cycle bus events, all derived from synchronized SCL/SDA.
    typedef struct packed {
        logic scl_rise;
        logic scl_fall;
        logic start;
        logic stop;
    } i2c_cond_t;

    // Upper seven bits of the first byte carry the device address.
    function automatic logic addr_match(input logic [7:0] rx_byte,
                                        input logic [6:0] dev_addr);
        return rx_byte[7:1] == dev_addr;
    endfunction

endpackage

// File: rtl/i2c_deserializer_cond.sv
// i2c_cond_detect
//   Synchronizes raw SCL/SDA into the Clock domain and flags SCL edges and
//   START/STOP conditions.
//   Ports:
//     Clock, reset      - system clock, async active-low reset
//     i2c_scl, i2c_sda_in - raw bus lines
//     sda_sync          - synchronized SDA (for data sampling)
//     cond              - one-cycle scl_rise / scl_fall / start / stop pulses
import i2c_deserializer_pkg::*;

module i2c_cond_detect (
    input  logic      Clock,
    input  logic      reset,
    input  logic      i2c_scl,
    input  logic      i2c_sda_in,
    output logic      sda_sync,
    output i2c_cond_t cond
);

    logic [1:0] scl_pipe;
    logic [1:0] sda_pipe;
    logic       scl_prev;
    logic       sda_prev;
    logic       scl_s;

    // Everything resets high: an idle bus, so leaving reset never looks
    // like an SDA fall with SCL high.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            scl_pipe <= 2'b11;
            sda_pipe <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_pipe <= {scl_pipe[0], i2c_scl};
            sda_pipe <= {sda_pipe[0], i2c_sda_in};
            scl_prev <= scl_pipe[1];
            sda_prev <= sda_pipe[1];
        end
    end

    assign scl_s    = scl_pipe[1];
    assign sda_sync = sda_pipe[1];

    // START/STOP require SCL high on both sides of the SDA transition so an
    // SDA change racing an SCL edge is not mistaken for a bus condition.
    always_comb begin
        cond          = '0;
        cond.scl_rise = scl_s & ~scl_prev;
        cond.scl_fall = ~scl_s & scl_prev;
        cond.start    = scl_s & scl_prev & sda_prev & ~sda_sync;
        cond.stop     = scl_s & scl_prev & ~sda_prev & sda_sync;
    end

endmodule

// File: rtl/i2c_deserializer.sv
// i2c_deserializer
//   I2C slave receive FSM. Decodes device address, register pointer and write
//   data; issues write strobes and read-fetch strobes for the serializer.
//   Ports:
//     Clock, reset        - system clock, async active-low reset
//     i2c_scl, i2c_sda_in - raw bus lines
//     i2c_ack             - high across each slave ACK bit window
//     i2c_xfc_read        - one-cycle read fetch, address on i2c_raddr
//     i2c_xfc_write       - one-cycle write, i2c_waddr / i2c_wdata
//     i2c_busy            - addressed, until next START or STOP
import i2c_deserializer_pkg::*;

module i2c_deserializer #(
    parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic       i2c_scl,
    input  logic       i2c_sda_in,
    output logic       i2c_ack,
    output logic       i2c_xfc_read,
    output logic [7:0] i2c_raddr,
    output logic       i2c_xfc_write,
    output logic [7:0] i2c_waddr,
    output logic [7:0] i2c_wdata,
    output logic       i2c_busy
);

    localparam logic [3:0] LAST_BIT = 4'(BITS_PER_BYTE);

    i2c_cond_t  cond;
    logic       sda_sync;
    i2c_state_e state;
    logic [7:0] shift_reg;
    logic [3:0] bit_cnt;
    logic [7:0] reg_ptr;
    logic       rw_bit;
    logic       mst_nack;
    logic       byte_done;

    i2c_cond_detect u_cond (
        .Clock      (Clock),
        .reset      (reset),
        .i2c_scl    (i2c_scl),
        .i2c_sda_in (i2c_sda_in),
        .sda_sync   (sda_sync),
        .cond       (cond)
    );

    // Eight bits captured; the next SCL fall closes the byte.
    assign byte_done = (bit_cnt == LAST_BIT);

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            shift_reg     <= '0;
            bit_cnt       <= '0;
            reg_ptr       <= '0;
            rw_bit        <= 1'b0;
            mst_nack      <= 1'b0;
            i2c_ack       <= 1'b0;
            i2c_xfc_read  <= 1'b0;
            i2c_raddr     <= '0;
            i2c_xfc_write <= 1'b0;
            i2c_waddr     <= '0;
            i2c_wdata     <= '0;
            i2c_busy      <= 1'b0;
        end else begin
            i2c_xfc_read  <= 1'b0;
            i2c_xfc_write <= 1'b0;

            // Bus conditions pre-empt everything; strobes only fire on a
            // completed byte, so a partial byte is dropped silently.
            if (cond.start) begin
                state     <= DEV_ADDR;
                shift_reg <= '0;
                bit_cnt   <= '0;
                i2c_ack   <= 1'b0;
                i2c_busy  <= 1'b0;
            end else if (cond.stop) begin
                state     <= IDLE;
                shift_reg <= '0;
                bit_cnt   <= '0;
                i2c_ack   <= 1'b0;
                i2c_busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;

                    DEV_ADDR, REG_ADDR, WR_DATA: begin
                        if (cond.scl_rise && !byte_done) begin
                            shift_reg <= {shift_reg[6:0], sda_sync};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end
                        if (cond.scl_fall && byte_done) begin
                            bit_cnt <= '0;
                            if (state == DEV_ADDR) begin
                                if (addr_match(shift_reg, SLAVE_ADDR)) begin
                                    state    <= ACK_DEV;
                                    i2c_ack  <= 1'b1;
                                    i2c_busy <= 1'b1;
                                    rw_bit   <= shift_reg[0];
                                    // First read byte is fetched as the ACK
                                    // starts so the serializer has it ready.
                                    if (shift_reg[0]) begin
                                        i2c_xfc_read <= 1'b1;
                                        i2c_raddr    <= reg_ptr;
                                    end
                                end else begin
                                    state <= IDLE;
                                end
                            end else if (state == REG_ADDR) begin
                                reg_ptr <= shift_reg;
                                i2c_ack <= 1'b1;
                                state   <= ACK_REG;
                            end else begin
                                i2c_xfc_write <= 1'b1;
                                i2c_waddr     <= reg_ptr;
                                i2c_wdata     <= shift_reg;
                                reg_ptr       <= reg_ptr + 8'd1;
                                i2c_ack       <= 1'b1;
                                state         <= ACK_WR;
                            end
                        end
                    end

                    ACK_DEV: begin
                        if (cond.scl_fall) begin
                            i2c_ack <= 1'b0;
                            state   <= rw_bit ? RD_BYTE : REG_ADDR;
                        end
                    end

                    ACK_REG, ACK_WR: begin
                        if (cond.scl_fall) begin
                            i2c_ack <= 1'b0;
                            state   <= WR_DATA;
                        end
                    end

                    // SDA belongs to the serializer here; just count bits.
                    RD_BYTE: begin
                        if (cond.scl_rise && !byte_done)
                            bit_cnt <= bit_cnt + 4'd1;
                        if (cond.scl_fall && byte_done) begin
                            bit_cnt <= '0;
                            state   <= MST_ACK;
                        end
                    end

                    MST_ACK: begin
                        if (cond.scl_rise)
                            mst_nack <= sda_sync;
                        if (cond.scl_fall) begin
                            if (!mst_nack) begin
                                reg_ptr      <= reg_ptr + 8'd1;
                                i2c_xfc_read <= 1'b1;
                                i2c_raddr    <= reg_ptr + 8'd1;
                                state        <= RD_BYTE;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_deserializer.sv
module tb_i2c_deserializer;

    localparam logic [6:0] SLAVE = 7'h50;
    localparam int         PH    = 5;  // clocks per SCL quarter step

    logic       Clock = 1'b0;
    logic       reset = 1'b0;
    logic       scl   = 1'b1;
    logic       sda   = 1'b1;
    logic       i2c_ack, i2c_xfc_read, i2c_xfc_write, i2c_busy;
    logic [7:0] i2c_raddr, i2c_waddr, i2c_wdata;

    i2c_deserializer #(.SLAVE_ADDR(SLAVE)) dut (
        .Clock         (Clock),
        .reset         (reset),
        .i2c_scl       (scl),
        .i2c_sda_in    (sda),
        .i2c_ack       (i2c_ack),
        .i2c_xfc_read  (i2c_xfc_read),
        .i2c_raddr     (i2c_raddr),
        .i2c_xfc_write (i2c_xfc_write),
        .i2c_waddr     (i2c_waddr),
        .i2c_wdata     (i2c_wdata),
        .i2c_busy      (i2c_busy)
    );

    always #5 Clock = ~Clock;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: register pointer plus expected event lists.
    logic [7:0]  m_ptr = 8'h00;
    logic [15:0] exp_w[$], obs_w[$];
    logic [7:0]  exp_r[$], obs_r[$];
    int          exp_acks = 0, obs_acks = 0;
    logic [7:0]  wdat[8];
    bit          in_rd = 0, ack_in_rd = 0;
    int          ack_len = 0;
    logic        ack_q = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor, sampled on the falling clock edge.
    always @(negedge Clock) begin
        if (i2c_xfc_write) begin
            obs_w.push_back({i2c_waddr, i2c_wdata});
            chk("wr_at_ack_rise", {31'b0, i2c_ack & ~ack_q}, 32'd1);
        end
        if (i2c_xfc_read) obs_r.push_back(i2c_raddr);
        if (i2c_ack && !ack_q) obs_acks++;
        if (in_rd && i2c_ack) ack_in_rd = 1;
        if (i2c_ack) ack_len++;
        else if (ack_q) begin
            // ACK spans from the 8th to the 9th SCL fall: three quarter steps.
            if (reset) chk("ack_width", ack_len, 3 * PH);
            ack_len = 0;
        end
        ack_q = i2c_ack;
    end

    task automatic wait_ph;
        repeat (PH) @(posedge Clock);
        #1;
    endtask

    task automatic bus_start;
        sda = 1'b1; wait_ph;
        scl = 1'b1; wait_ph;
        sda = 1'b0; wait_ph;
        scl = 1'b0; wait_ph;
    endtask

    task automatic bus_stop;
        sda = 1'b0; wait_ph;
        scl = 1'b1; wait_ph;
        sda = 1'b1; wait_ph;
    endtask

    task automatic send_bit(input logic b);
        sda = b;    wait_ph;
        scl = 1'b1; wait_ph;
        scl = 1'b0; wait_ph;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic check_tx(input string tag);
        chk({tag, "_wr_count"}, obs_w.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++)
            chk({tag, "_wr_addr_data"}, obs_w[i], exp_w[i]);
        chk({tag, "_rd_count"}, obs_r.size(), exp_r.size());
        for (int i = 0; i < exp_r.size() && i < obs_r.size(); i++)
            chk({tag, "_raddr"}, obs_r[i], exp_r[i]);
        chk({tag, "_ack_windows"}, obs_acks, exp_acks);
        chk({tag, "_no_ack_in_read"}, ack_in_rd, 0);
        chk({tag, "_busy_idle"}, i2c_busy, 0);
        exp_w.delete(); obs_w.delete(); exp_r.delete(); obs_r.delete();
        exp_acks = 0; obs_acks = 0; ack_in_rd = 0;
    endtask

    task automatic tx_write(input logic [7:0] dev, input logic [7:0] ra, input int n);
        bus_start;
        send_byte(dev);
        if (dev[7:1] != SLAVE || dev[0]) begin
            send_bit(1'b1);  // nobody acknowledges
            chk("mismatch_busy", i2c_busy, 0);
        end else begin
            send_bit(1'b0); exp_acks++;
            chk("match_busy", i2c_busy, 1);
            send_byte(ra); send_bit(1'b0); exp_acks++;
            m_ptr = ra;
            for (int k = 0; k < n; k++) begin
                send_byte(wdat[k]); send_bit(1'b0); exp_acks++;
                exp_w.push_back({m_ptr, wdat[k]});
                m_ptr = m_ptr + 8'd1;
            end
        end
        bus_stop; wait_ph;
    endtask

    task automatic tx_read(input bit set_ptr, input logic [7:0] ra, input int n);
        if (set_ptr) begin
            bus_start;
            send_byte({SLAVE, 1'b0}); send_bit(1'b0);
            send_byte(ra); send_bit(1'b0);
            exp_acks += 2;
            m_ptr = ra;
        end
        bus_start;
        send_byte({SLAVE, 1'b1}); send_bit(1'b0); exp_acks++;
        chk("read_busy", i2c_busy, 1);
        exp_r.push_back(m_ptr);
        in_rd = 1;
        for (int k = 0; k < n; k++) begin
            send_byte(8'($urandom));
            send_bit(k == n - 1);  // ACK all but the last byte
            if (k < n - 1) begin
                m_ptr = m_ptr + 8'd1;
                exp_r.push_back(m_ptr);
            end
        end
        in_rd = 0;
        bus_stop; wait_ph;
    endtask

    task automatic tx_abort(input logic [7:0] ra, input int nbits);
        bus_start;
        send_byte({SLAVE, 1'b0}); send_bit(1'b0);
        send_byte(ra); send_bit(1'b0);
        exp_acks += 2;
        m_ptr = ra;
        for (int i = 0; i < nbits; i++) send_bit(1'($urandom));
        bus_stop; wait_ph;
        chk("abort_ack_low", i2c_ack, 0);
    endtask

    initial begin
        repeat (3) @(posedge Clock);
        #1;
        chk("reset_outputs", {i2c_ack, i2c_xfc_read, i2c_xfc_write, i2c_busy,
                              i2c_raddr, i2c_waddr, i2c_wdata}, 0);
        reset = 1'b1;
        wait_ph;
        chk("post_reset_busy", i2c_busy, 0);

        // Single write.
        wdat[0] = 8'h5A;
        tx_write(8'hA0, 8'h10, 1);
        check_tx("write1");

        // Wrong device address.
        tx_write(8'hA2, 8'h00, 0);
        check_tx("mismatch");

        // Random read across the pointer wrap.
        tx_read(1, 8'hFF, 2);
        check_tx("read_wrap");

        // Burst write across the pointer wrap.
        wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33;
        tx_write(8'hA0, 8'hFE, 3);
        check_tx("burst");

        // STOP four bits into a data byte.
        tx_abort(8'h40, 4);
        check_tx("abort");

        // Reset while the slave is acknowledging a data byte.
        bus_start;
        send_byte({SLAVE, 1'b0}); send_bit(1'b0);
        send_byte(8'h77); send_bit(1'b0);
        send_byte(8'hC3);
        exp_acks += 3;
        exp_w.push_back({8'h77, 8'hC3});
        sda = 1'b0; wait_ph;
        reset = 1'b0; #1;
        chk("reset_in_ack_wr", {i2c_ack, i2c_xfc_read, i2c_xfc_write, i2c_busy,
                                i2c_raddr, i2c_waddr, i2c_wdata}, 0);
        m_ptr = 8'h00;
        scl = 1'b1; sda = 1'b1; wait_ph;
        reset = 1'b1; wait_ph;
        check_tx("reset_mid");
        tx_read(0, 8'h00, 2);  // current-address read from the cleared pointer
        check_tx("after_reset_read");
        wdat[0] = 8'hE7;
        tx_write(8'hA0, 8'h33, 1);
        check_tx("after_reset_write");

        // Randomized transactions against the model.
        for (int t = 0; t < 12; t++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            if (kind == 0) begin
                int n;
                n = int'($urandom_range(1, 4));
                for (int k = 0; k < n; k++) wdat[k] = 8'($urandom);
                tx_write(8'hA0, 8'($urandom), n);
            end else if (kind == 1) begin
                tx_read(1'($urandom), 8'($urandom), int'($urandom_range(1, 3)));
            end else if (kind == 2) begin
                logic [7:0] dev;
                dev = 8'($urandom);
                if (dev[7:1] == SLAVE) dev[1] = ~dev[1];
                tx_write(dev, 8'h00, 0);
            end else begin
                tx_abort(8'($urandom), int'($urandom_range(1, 7)));
            end
            check_tx("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
